// File: rtl/jt_dsp16_pkg.sv
// Shared definitions for the reduced DSP16 core: opcode fields, register codes,
// sequencer states and the program-counter source selector.
package jt_dsp16_pkg;

    localparam int ROMW_DEF = 12;

    // The jump and immediate forms only fix the upper four T bits.
    localparam logic [3:0] T4_GOTO_JA   = 4'b0000;
    localparam logic [3:0] T4_CALL_JA   = 4'b1000;
    localparam logic [3:0] T4_SHORT_IMM = 4'b0110;
    localparam logic [4:0] T_GOTO_B     = 5'b11000;
    localparam logic [4:0] T_LONG_IMM   = 5'b01010;

    localparam logic [2:0] B_RETURN  = 3'd0;
    localparam logic [2:0] B_IRETURN = 3'd1;
    localparam logic [2:0] B_GOTO_PT = 3'd2;
    localparam logic [2:0] B_CALL_PT = 3'd3;

    localparam logic [5:0] R_R0 = 6'd0;
    localparam logic [5:0] R_R1 = 6'd1;
    localparam logic [5:0] R_R2 = 6'd2;
    localparam logic [5:0] R_R3 = 6'd3;
    localparam logic [5:0] R_J  = 6'd4;
    localparam logic [5:0] R_K  = 6'd5;
    localparam logic [5:0] R_RB = 6'd6;
    localparam logic [5:0] R_RE = 6'd7;
    localparam logic [5:0] R_PT = 6'd8;
    localparam logic [5:0] R_PR = 6'd9;
    localparam logic [5:0] R_PI = 6'd10;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_IMM   = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_JA   = 3'd2,
        PC_PR   = 3'd3,
        PC_PI   = 3'd4,
        PC_PT   = 3'd5
    } pc_sel_t;

    function automatic logic [15:0] sext9(input logic [8:0] m);
        return {{7{m[8]}}, m};
    endfunction

endpackage

// File: rtl/jt_dsp16_ram_aau.sv
// YAAU: data-address registers r0-r3, rb, re, j, k, loaded by immediates.
module jt_dsp16_ram_aau
    import jt_dsp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  logic        wr_en,
    input  logic [5:0]  wr_sel,
    input  logic [15:0] wr_data
);

    logic [15:0] r0;
    logic [15:0] r1;
    logic [15:0] r2;
    logic [15:0] r3;
    logic [15:0] j;
    logic [15:0] k;
    logic [15:0] rb;
    logic [15:0] re;

    // No data-memory path exists yet; the registers are observed hierarchically.
    logic unused_regs;
    assign unused_regs = ^{r0, r1, r2, r3, j, k, rb, re};

    always_ff @(posedge clk) begin
        if (cen) begin
            if (rst) begin
                r0 <= 16'h0000;
                r1 <= 16'h0000;
                r2 <= 16'h0000;
                r3 <= 16'h0000;
                j  <= 16'h0000;
                k  <= 16'h0000;
                rb <= 16'h0000;
                re <= 16'h0000;
            end else if (wr_en) begin
                case (wr_sel)
                    R_R0:    r0 <= wr_data;
                    R_R1:    r1 <= wr_data;
                    R_R2:    r2 <= wr_data;
                    R_R3:    r3 <= wr_data;
                    R_J:     j  <= wr_data;
                    R_K:     k  <= wr_data;
                    R_RB:    rb <= wr_data;
                    R_RE:    re <= wr_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/jt_dsp16_rom_aau.sv
// XAAU: program counter and its companion pointers pr, pi, pt, plus the
// next-pc selection that also drives the synchronous ROM read address.
module jt_dsp16_rom_aau
    import jt_dsp16_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        cen,
    input  pc_sel_t     pc_sel,
    input  logic [11:0] ja,
    input  logic        save_pr,
    input  logic        wr_en,
    input  logic [5:0]  wr_sel,
    input  logic [15:0] wr_data,
    output logic [15:0] pc,
    output logic [15:0] pc_next
);

    logic [15:0] pr;
    logic [15:0] pi;
    logic [15:0] pt;

    // pc_next is exported so the ROM can be addressed one cycle ahead.
    always_comb begin
        pc_next = pc;
        if (rst) begin
            pc_next = 16'h0000;
        end else begin
            case (pc_sel)
                PC_INC:  pc_next = pc + 16'd1;
                PC_JA:   pc_next = {pc[15:12], ja};
                PC_PR:   pc_next = pr;
                PC_PI:   pc_next = pi;
                PC_PT:   pc_next = pt;
                default: pc_next = pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (cen) begin
            pc <= pc_next;
            if (rst) begin
                pr <= 16'h0000;
                pi <= 16'h0000;
                pt <= 16'h0000;
            end else begin
                if (save_pr) begin
                    pr <= pc;
                end else if (wr_en && wr_sel == R_PR) begin
                    pr <= wr_data;
                end
                if (wr_en && wr_sel == R_PI) begin
                    pi <= wr_data;
                end
                if (wr_en && wr_sel == R_PT) begin
                    pt <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/jt_dsp16.sv
// Reduced DSP16 core top: program ROM, fetch source mux, sequencer and decode
// for the control-flow and register-immediate instruction subset.
module jt_dsp16
    import jt_dsp16_pkg::*;
#(
    parameter int ROMW = ROMW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cen,
    output logic [15:0]     ext_addr,
    input  logic [15:0]     ext_data,
    input  logic [ROMW-1:0] prog_addr,
    input  logic [15:0]     prog_data,
    input  logic            prog_we
);

    logic [15:0] rom [0:(1<<ROMW)-1];
    logic [15:0] rom_q;
    logic [15:0] fetch_word;
    logic [15:0] ir;
    logic [15:0] pc;
    logic [15:0] pc_next;

    state_t      state;
    state_t      state_next;
    pc_sel_t     pc_sel;
    logic        save_pr;
    logic        wr_en;
    logic [5:0]  wr_sel;
    logic [15:0] wr_data;

    // Reading at pc_next makes rom_q hold rom[pc] in whichever cycle uses it;
    // a same-cycle write to that address is only seen on the next read.
    always_ff @(posedge clk) begin
        if (cen) begin
            if (prog_we) begin
                rom[prog_addr] <= prog_data;
            end
            rom_q <= rom[pc_next[ROMW-1:0]];
        end
    end

    assign fetch_word = (pc[15:ROMW] == '0) ? rom_q : ext_data;
    assign ext_addr   = rst ? 16'h0000 : pc;

    always_ff @(posedge clk) begin
        if (cen) begin
            if (rst) begin
                state <= S_FETCH;
                ir    <= 16'h0000;
            end else begin
                state <= state_next;
                if (state == S_FETCH) begin
                    ir <= fetch_word;
                end
            end
        end
    end

    // pc already points past the opcode in EXEC, so plain nops simply hold it.
    always_comb begin
        state_next = state;
        pc_sel     = PC_HOLD;
        save_pr    = 1'b0;
        wr_en      = 1'b0;
        wr_sel     = ir[9:4];
        wr_data    = fetch_word;
        case (state)
            S_FETCH: begin
                pc_sel     = PC_INC;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                state_next = S_FETCH;
                if (ir[15:12] == T4_GOTO_JA) begin
                    pc_sel = PC_JA;
                end else if (ir[15:12] == T4_CALL_JA) begin
                    pc_sel  = PC_JA;
                    save_pr = 1'b1;
                end else if (ir[15:11] == T_GOTO_B) begin
                    case (ir[10:8])
                        B_RETURN:  pc_sel = PC_PR;
                        B_IRETURN: pc_sel = PC_PI;
                        B_GOTO_PT: pc_sel = PC_PT;
                        B_CALL_PT: begin
                            pc_sel  = PC_PT;
                            save_pr = 1'b1;
                        end
                        default: ;
                    endcase
                end else if (ir[15:11] == T_LONG_IMM) begin
                    state_next = S_IMM;
                end else if (ir[15:12] == T4_SHORT_IMM) begin
                    wr_en   = 1'b1;
                    wr_sel  = {3'b000, ir[11:9]};
                    wr_data = sext9(ir[8:0]);
                end
            end
            S_IMM: begin
                wr_en      = 1'b1;
                pc_sel     = PC_INC;
                state_next = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase
    end

    jt_dsp16_rom_aau u_rom_aau (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .pc_sel  (pc_sel),
        .ja      (ir[11:0]),
        .save_pr (save_pr),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .pc      (pc),
        .pc_next (pc_next)
    );

    jt_dsp16_ram_aau u_ram_aau (
        .clk     (clk),
        .rst     (rst),
        .cen     (cen),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data)
    );

endmodule

// File: tb/tb_jt_dsp16.sv
// Directed bench for jt_dsp16: loads small programs through the prog port
// during reset, runs them and checks registers and ext_addr against hand values.
module tb_jt_dsp16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cen;
    logic [15:0] ext_addr;
    logic [15:0] ext_data;
    logic [11:0] prog_addr;
    logic [15:0] prog_data;
    logic        prog_we;

    int total = 0;
    int bad   = 0;

    logic [15:0] prog [$];

    always #5 clk = ~clk;

    jt_dsp16 dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .ext_addr  (ext_addr),
        .ext_data  (ext_data),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .prog_we   (prog_we)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic loadWord(input logic [11:0] a, input logic [15:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        tick(1);
        prog_we   = 1'b0;
    endtask

    // Holds the core in reset and writes a block of words starting at base.
    task automatic applyStimulus(input logic [11:0] base, input logic [15:0] words [$]);
        rst = 1'b1;
        cen = 1'b1;
        foreach (words[i]) begin
            loadWord(base + 12'(i), words[i]);
        end
    endtask

    task automatic releaseReset();
        tick(1);
        rst = 1'b0;
    endtask

    function automatic logic [15:0] fillWord(input int i);
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    initial begin
        int errs;
        rst       = 1'b1;
        cen       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = 12'h000;
        prog_data = 16'h0000;
        ext_data  = 16'h0000;
        tick(2);

        checkOutput("rst_ext_addr", ext_addr, 16'h0000);
        checkOutput("rst_pc", dut.u_rom_aau.pc, 16'h0000);
        checkOutput("rst_pr", dut.u_rom_aau.pr, 16'h0000);
        checkOutput("rst_r0", dut.u_ram_aau.r0, 16'h0000);
        checkOutput("rst_k", dut.u_ram_aau.k, 16'h0000);
        checkOutput("rst_state", 16'(dut.state), 16'h0000);
        checkOutput("rst_ir", dut.ir, 16'h0000);

        // ROM fill 0..511 while held in reset
        for (int i = 0; i < 512; i++) begin
            loadWord(12'(i), fillWord(i));
        end
        tick(1);
        errs = 0;
        for (int i = 0; i < 512; i++) begin
            if (dut.rom[i] !== fillWord(i)) errs++;
        end
        checkOutput("rom_fill_errs", 16'(errs), 16'h0000);

        // register loads: r0=N 0x1234, r3=M -1, j=M 5, k=N 0xBEEF
        prog = {16'h5000, 16'h1234, 16'h67FF, 16'h6805, 16'h5050, 16'hBEEF, 16'h0026};
        applyStimulus(12'h020, prog);
        prog = {16'h0020};
        applyStimulus(12'h000, prog);
        releaseReset();
        tick(20);
        checkOutput("ld_r0", dut.u_ram_aau.r0, 16'h1234);
        checkOutput("ld_r1", dut.u_ram_aau.r1, 16'h0000);
        checkOutput("ld_r2", dut.u_ram_aau.r2, 16'h0000);
        checkOutput("ld_r3", dut.u_ram_aau.r3, 16'hFFFF);
        checkOutput("ld_j", dut.u_ram_aau.j, 16'h0005);
        checkOutput("ld_k", dut.u_ram_aau.k, 16'hBEEF);
        checkOutput("ld_rb", dut.u_ram_aau.rb, 16'h0000);
        checkOutput("ld_re", dut.u_ram_aau.re, 16'h0000);
        checkOutput("ld_pt", dut.u_rom_aau.pt, 16'h0000);
        checkOutput("ld_pr", dut.u_rom_aau.pr, 16'h0000);
        checkOutput("ld_pi", dut.u_rom_aau.pi, 16'h0000);

        // same program with cen toggling: 12 enabled edges needed for k
        prog = {16'h0020};
        applyStimulus(12'h000, prog);
        releaseReset();
        for (int i = 1; i <= 22; i++) begin
            cen = (i % 2) == 1;
            tick(1);
        end
        checkOutput("cen_half_r0", dut.u_ram_aau.r0, 16'h1234);
        checkOutput("cen_half_k", dut.u_ram_aau.k, 16'h0000);
        for (int i = 23; i <= 24; i++) begin
            cen = (i % 2) == 1;
            tick(1);
        end
        cen = 1'b1;
        checkOutput("cen_r3", dut.u_ram_aau.r3, 16'hFFFF);
        checkOutput("cen_j", dut.u_ram_aau.j, 16'h0005);
        checkOutput("cen_k", dut.u_ram_aau.k, 16'hBEEF);

        // call 0x010 from 0x002, subroutine sets pt and returns
        prog = {16'h5080, 16'h0030, 16'hC000};
        applyStimulus(12'h010, prog);
        prog = {16'hF800, 16'hF800, 16'h8010, 16'h0003};
        applyStimulus(12'h000, prog);
        releaseReset();
        tick(11);
        checkOutput("call_ret_pc", ext_addr, 16'h0003);
        checkOutput("call_pr", dut.u_rom_aau.pr, 16'h0003);
        checkOutput("call_pt", dut.u_rom_aau.pt, 16'h0030);
        tick(1);
        checkOutput("call_loop_exec", ext_addr, 16'h0004);
        tick(1);
        checkOutput("call_loop_fetch", ext_addr, 16'h0003);

        // goto 0x100 self-loop
        prog = {16'h0100};
        applyStimulus(12'h100, prog);
        applyStimulus(12'h000, prog);
        releaseReset();
        checkOutput("loop_c0", ext_addr, 16'h0000);
        tick(1);
        checkOutput("loop_c1", ext_addr, 16'h0001);
        tick(1);
        checkOutput("loop_c2", ext_addr, 16'h0100);
        tick(1);
        checkOutput("loop_c3", ext_addr, 16'h0101);
        tick(1);
        checkOutput("loop_c4", ext_addr, 16'h0100);
        tick(1);
        checkOutput("loop_c5", ext_addr, 16'h0101);
        rst = 1'b1;
        #1;
        checkOutput("loop_rst_ext_addr", ext_addr, 16'h0000);

        // pi=N 0x0040 then ireturn
        prog = {16'h50A0, 16'h0040, 16'hC100};
        applyStimulus(12'h050, prog);
        prog = {16'h0050};
        applyStimulus(12'h000, prog);
        releaseReset();
        tick(7);
        checkOutput("iret_pi", dut.u_rom_aau.pi, 16'h0040);
        checkOutput("iret_pc", ext_addr, 16'h0040);

        // reset during the immediate word of k=N
        prog = {16'h5050, 16'h7777, 16'h0042};
        applyStimulus(12'h040, prog);
        prog = {16'h0040};
        applyStimulus(12'h000, prog);
        releaseReset();
        tick(4);
        checkOutput("abort_in_imm", 16'(dut.state), 16'(2));
        rst = 1'b1;
        tick(1);
        checkOutput("abort_k", dut.u_ram_aau.k, 16'h0000);
        checkOutput("abort_pc", dut.u_rom_aau.pc, 16'h0000);
        checkOutput("abort_state", 16'(dut.state), 16'h0000);
        tick(2);
        rst = 1'b0;
        tick(5);
        checkOutput("abort_rerun_k", dut.u_ram_aau.k, 16'h7777);

        // jump through pt into external memory and execute r3=M from ext_data
        ext_data = 16'h67F5;
        prog = {16'h5080, 16'h2000, 16'hC200};
        applyStimulus(12'h060, prog);
        prog = {16'h0060};
        applyStimulus(12'h000, prog);
        releaseReset();
        tick(9);
        checkOutput("ext_pc", ext_addr, 16'h2001);
        checkOutput("ext_r3", dut.u_ram_aau.r3, 16'hFFF5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
